sdram_responder: RTL and testbench
==================================

Name: sdram_responder

Overview:
- Synthesizable pin-level SDRAM device responder: the chip-side end of the SDRAM pin interface our controller drives.
- Decodes CS/RAS/CAS/WE commands, tracks the open row per bank, holds a mode register, and performs burst writes into internal storage.
- Returns burst read data on dq with the programmed CAS latency.
- Used in-fabric for controller loopback/self-test and as the bench responder for the controller's pin wrapper.
- Storage is reduced-size; row/column bits above the parameterized widths are ignored.

Parameters:
- ROW_BITS, 4, row address bits stored, taken from a[ROW_BITS-1:0]; ≤13.
- COL_BITS, 4, column address bits stored, taken from a[COL_BITS-1:0]; ≤9, ≥3.
- Storage depth = 4 * 2^ROW_BITS * 2^COL_BITS words x16; default 1024.

Ports:
- clk  in  1  device clock; all pin inputs sampled on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cke  in  1  clock enable.
- cs_n  in  1  chip select, active low.
- ras_n  in  1  command bit 2.
- cas_n  in  1  command bit 1.
- we_n  in  1  command bit 0.
- dqm  in  2  byte masks; bit1 = dq[15:8].
- a  in  13  address / mode word.
- ba  in  2  bank select.
- dq_in  in  16  write data from pad.
- dq_out  out  16  read data to pad.
- dq_oe  out  2  per-byte output enable; bit1 = dq[15:8].
- refresh_cnt  out  16  AUTO REFRESH count; wraps.
- cmd_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (async, rst_n=0):
  - dq_out=0, dq_oe=0, refresh_cnt=0, cmd_err=0.
  - All banks idle; bursts cancelled; read pipeline flushed.
  - Mode register: BL=1, CL=2.
  - Storage contents are not reset.
- cke=0: the sampled command is ignored. All state, including burst counters and the read pipeline, holds; outputs hold.
- Command decode when cs_n=0, {ras_n,cas_n,we_n}. cs_n=1 is treated as NOP.
  - 111 NOP: no action.
  - 011 ACTIVE: open row a in bank ba.
    - If bank ba is already active: cmd_err set; row unchanged.
  - 101 READ: start read burst at column a in bank ba.
  - 100 WRITE: start write burst at column a in bank ba.
  - READ/WRITE to an idle bank: cmd_err set; command ignored.
  - READ/WRITE with a[10]=1: auto-precharge the bank when the burst completes or is interrupted.
  - 010 PRECHARGE: a[10]=1 closes all banks; else closes bank ba.
    - If the closed bank has a burst in progress, that burst stops (write beats not yet taken are dropped; read beats not yet issued are not issued).
  - 001 AUTO REFRESH: refresh_cnt+1.
    - If any bank is active: cmd_err set.
  - 000 LOAD MODE: BL from a[2:0] (000=1, 001=2, 010=4, 011=8; other codes=1); CL from a[6:4] (2 or 3; other codes=2).
    - If any bank is active or a burst is in progress: cmd_err set; mode unchanged.
  - 110 BURST TERMINATE: stops the current burst after this edge.
- Write burst:
  - Beat 0 data is dq_in on the WRITE edge; beat k is taken on edge k.
  - Byte written only where the same-cycle dqm bit = 0.
- Read burst:
  - Beat k is issued on edge k after READ.
  - Data appears on dq_out/dq_oe CL cycles after issue: READ sampled at edge T → beat 0 valid after edge T+CL.
  - dq_oe[b] = 1 for issued beats unless dqm[b] was 1 two edges before the output edge (DQM read latency 2).
  - dq_oe returns to 0 the cycle after the last beat.
- Burst addressing: sequential, wrapping within the BL-aligned column block. Example: BL=4, start col 6 → 6,7,4,5.
- Interruption:
  - New READ/WRITE truncates the current burst; the new burst starts at that edge.
  - WRITE during the read CL window: already-issued read beats are still driven. Bench owns the bus turn-around; overlap is not checked.
- READ and write beat to the same address on the same edge: the read returns the old data.

Test Plan:
- Reset, LOAD MODE a=0x022 (BL=4, CL=2), ACTIVE ba=1 row 3, WRITE col 0 with data 0x1111..0x4444 → READ col 0: dq_oe=2'b11 and data 0x1111,0x2222,0x3333,0x4444 on edges T+2..T+5; dq_oe=0 at T+6.
- WRITE with dqm=2'b10 data 0xABCD over 0x1234 → read back 0x12CD.
- BL=8, READ col 5 → column order 5,6,7,0,1,2,3,4. Change CL to 3 → first beat at T+3.
- READ BL=8 followed by BURST TERMINATE 2 cycles later → exactly 2 beats driven, then dq_oe=0.
- READ to idle bank → cmd_err=1 and dq_oe stays 0. AUTO REFRESH x3 with all banks idle → refresh_cnt=3.
- cke=0 for 3 cycles mid-burst → dq_out/dq_oe held, burst resumes intact. rst_n low mid-burst → dq_oe=0 immediately, mode back to BL=1/CL=2.

Source files
------------

// File: rtl/sdram_responder_if.sv
// Pin-level SDRAM bus between a controller (master) and the device responder (slave).
interface sdram_responder_if;
    logic        cke;
    logic        cs_n;
    logic        ras_n;
    logic        cas_n;
    logic        we_n;
    logic [1:0]  dqm;
    logic [12:0] a;
    logic [1:0]  ba;
    logic [15:0] dq_in;
    logic [15:0] dq_out;
    logic [1:0]  dq_oe;
    logic [15:0] refresh_cnt;
    logic        cmd_err;

    modport master (
        output cke, cs_n, ras_n, cas_n, we_n, dqm, a, ba, dq_in,
        input  dq_out, dq_oe, refresh_cnt, cmd_err
    );

    modport slave (
        input  cke, cs_n, ras_n, cas_n, we_n, dqm, a, ba, dq_in,
        output dq_out, dq_oe, refresh_cnt, cmd_err
    );
endinterface

// File: rtl/sdram_responder.sv
// SDRAM device responder: command decode, per-bank open rows, mode register,
// burst writes into reduced storage and CAS-latency burst reads onto dq.
module sdram_responder #(
    parameter int unsigned ROW_BITS = 4,
    parameter int unsigned COL_BITS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    sdram_responder_if.slave bus
);
    localparam int unsigned AW    = 2 + ROW_BITS + COL_BITS;
    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic [2:0] {
        CMD_LMR = 3'b000,
        CMD_REF = 3'b001,
        CMD_PRE = 3'b010,
        CMD_ACT = 3'b011,
        CMD_WR  = 3'b100,
        CMD_RD  = 3'b101,
        CMD_BST = 3'b110,
        CMD_NOP = 3'b111
    } cmd_e;

    typedef enum logic [1:0] {
        BURST_IDLE,
        BURST_WRITE,
        BURST_READ
    } burst_e;

    cmd_e cmd;
    assign cmd = bus.cs_n ? CMD_NOP : cmd_e'({bus.ras_n, bus.cas_n, bus.we_n});

    logic [3:0]          bank_act_q, bank_act_d;
    logic [ROW_BITS-1:0] bank_row_q [4];
    logic [ROW_BITS-1:0] bank_row_d [4];
    logic [3:0]          bl_q, bl_d;
    logic [1:0]          cl_q, cl_d;
    burst_e              burst_q, burst_d;
    logic [1:0]          bbank_q, bbank_d;
    logic [ROW_BITS-1:0] brow_q, brow_d;
    logic [COL_BITS-1:0] bcol_q, bcol_d;
    logic [2:0]          bcnt_q, bcnt_d;
    logic                bap_q, bap_d;
    logic [15:0]         ref_q, ref_d;
    logic                err_q, err_d;

    logic [2:0]          pv_q, pv_d;
    logic [15:0]         pd_q [3];
    logic [15:0]         pd_d [3];
    logic [1:0]          dqm1_q, dqm1_d, dqm2_q, dqm2_d;
    logic [15:0]         dq_out_q, dq_out_d;
    logic [1:0]          dq_oe_q, dq_oe_d;

    logic                cont, new_burst, stop_cur;
    logic [3:0]          close;
    logic                beat_en, beat_wr;
    logic [1:0]          beat_bank;
    logic [ROW_BITS-1:0] beat_row;
    logic [COL_BITS-1:0] beat_col, bmask;
    logic [AW-1:0]       beat_addr;
    logic [15:0]         rd_data;
    logic [15:0]         mem [DEPTH];
    logic                unused_a;

    assign unused_a  = ^bus.a;
    assign cont      = (burst_q != BURST_IDLE);
    assign bmask     = COL_BITS'(bl_q - 4'd1);
    assign beat_addr = {beat_bank, beat_row, beat_col};
    assign rd_data   = mem[beat_addr];

    always_comb begin
        bank_act_d = bank_act_q;
        bank_row_d = bank_row_q;
        bl_d       = bl_q;
        cl_d       = cl_q;
        burst_d    = burst_q;
        bbank_d    = bbank_q;
        brow_d     = brow_q;
        bcol_d     = bcol_q;
        bcnt_d     = bcnt_q;
        bap_d      = bap_q;
        ref_d      = ref_q;
        err_d      = err_q;
        new_burst  = 1'b0;
        stop_cur   = 1'b0;
        close      = '0;
        beat_en    = 1'b0;
        beat_wr    = 1'b0;
        beat_bank  = bbank_q;
        beat_row   = brow_q;
        // Sequential order wrapping inside the BL-aligned column block.
        beat_col   = (bcol_q & ~bmask) | ((bcol_q + COL_BITS'(bcnt_q)) & bmask);

        if (bus.cke) begin
            case (cmd)
                CMD_ACT: begin
                    if (bank_act_q[bus.ba]) begin
                        err_d = 1'b1;
                    end else begin
                        bank_act_d[bus.ba] = 1'b1;
                        bank_row_d[bus.ba] = bus.a[ROW_BITS-1:0];
                    end
                end
                CMD_RD, CMD_WR: begin
                    if (!bank_act_q[bus.ba]) err_d = 1'b1;
                    else                     new_burst = 1'b1;
                end
                CMD_PRE: begin
                    close      = bus.a[10] ? 4'hF : (4'b0001 << bus.ba);
                    bank_act_d = bank_act_q & ~close;
                    if (cont && close[bbank_q]) stop_cur = 1'b1;
                end
                CMD_REF: begin
                    ref_d = ref_q + 16'd1;
                    if (|bank_act_q) err_d = 1'b1;
                end
                CMD_LMR: begin
                    if ((|bank_act_q) || cont) begin
                        err_d = 1'b1;
                    end else begin
                        case (bus.a[2:0])
                            3'b001:  bl_d = 4'd2;
                            3'b010:  bl_d = 4'd4;
                            3'b011:  bl_d = 4'd8;
                            default: bl_d = 4'd1;
                        endcase
                        cl_d = (bus.a[6:4] == 3'b011) ? 2'd3 : 2'd2;
                    end
                end
                CMD_BST: begin
                    if (cont) stop_cur = 1'b1;
                end
                default: ;
            endcase

            // Beat 0 happens on the command edge; the burst registers cover beats 1..BL-1.
            if (new_burst) begin
                if (cont && bap_q) bank_act_d[bbank_q] = 1'b0;
                beat_en   = 1'b1;
                beat_wr   = (cmd == CMD_WR);
                beat_bank = bus.ba;
                beat_row  = bank_row_q[bus.ba];
                beat_col  = bus.a[COL_BITS-1:0];
                bbank_d   = bus.ba;
                brow_d    = bank_row_q[bus.ba];
                bcol_d    = bus.a[COL_BITS-1:0];
                bcnt_d    = 3'd1;
                bap_d     = bus.a[10];
                if (bl_q == 4'd1) begin
                    burst_d = BURST_IDLE;
                    if (bus.a[10]) bank_act_d[bus.ba] = 1'b0;
                end else begin
                    burst_d = (cmd == CMD_WR) ? BURST_WRITE : BURST_READ;
                end
            end else if (stop_cur) begin
                burst_d = BURST_IDLE;
                if (bap_q) bank_act_d[bbank_q] = 1'b0;
            end else if (cont) begin
                beat_en = 1'b1;
                beat_wr = (burst_q == BURST_WRITE);
                bcnt_d  = bcnt_q + 3'd1;
                if ({1'b0, bcnt_q} == bl_q - 4'd1) begin
                    burst_d = BURST_IDLE;
                    if (bap_q) bank_act_d[bbank_q] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        pv_d     = pv_q;
        pd_d     = pd_q;
        dqm1_d   = dqm1_q;
        dqm2_d   = dqm2_q;
        dq_out_d = dq_out_q;
        dq_oe_d  = dq_oe_q;
        if (bus.cke) begin
            dqm1_d   = bus.dqm;
            dqm2_d   = dqm1_q;
            dq_out_d = pv_q[0] ? pd_q[0] : '0;
            dq_oe_d  = pv_q[0] ? ~dqm2_q : 2'b00;
            pv_d     = {1'b0, pv_q[2:1]};
            pd_d[0]  = pd_q[1];
            pd_d[1]  = pd_q[2];
            // Entry stage CL-1 puts the beat on the pins CL edges after issue.
            if (beat_en && !beat_wr) begin
                if (cl_q == 2'd3) begin
                    pv_d[2] = 1'b1;
                    pd_d[2] = rd_data;
                end else begin
                    pv_d[1] = 1'b1;
                    pd_d[1] = rd_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_act_q <= '0;
            for (int unsigned i = 0; i < 4; i++) bank_row_q[i] <= '0;
            bl_q       <= 4'd1;
            cl_q       <= 2'd2;
            burst_q    <= BURST_IDLE;
            bbank_q    <= '0;
            brow_q     <= '0;
            bcol_q     <= '0;
            bcnt_q     <= '0;
            bap_q      <= 1'b0;
            ref_q      <= '0;
            err_q      <= 1'b0;
            pv_q       <= '0;
            for (int unsigned i = 0; i < 3; i++) pd_q[i] <= '0;
            dqm1_q     <= '0;
            dqm2_q     <= '0;
            dq_out_q   <= '0;
            dq_oe_q    <= '0;
        end else begin
            bank_act_q <= bank_act_d;
            bank_row_q <= bank_row_d;
            bl_q       <= bl_d;
            cl_q       <= cl_d;
            burst_q    <= burst_d;
            bbank_q    <= bbank_d;
            brow_q     <= brow_d;
            bcol_q     <= bcol_d;
            bcnt_q     <= bcnt_d;
            bap_q      <= bap_d;
            ref_q      <= ref_d;
            err_q      <= err_d;
            pv_q       <= pv_d;
            pd_q       <= pd_d;
            dqm1_q     <= dqm1_d;
            dqm2_q     <= dqm2_d;
            dq_out_q   <= dq_out_d;
            dq_oe_q    <= dq_oe_d;
        end
    end

    always_ff @(posedge clk) begin
        if (beat_en && beat_wr) begin
            if (!bus.dqm[0]) mem[beat_addr][7:0]  <= bus.dq_in[7:0];
            if (!bus.dqm[1]) mem[beat_addr][15:8] <= bus.dq_in[15:8];
        end
    end

    assign bus.dq_out      = dq_out_q;
    assign bus.dq_oe       = dq_oe_q;
    assign bus.refresh_cnt = ref_q;
    assign bus.cmd_err     = err_q;
endmodule

// File: tb/tb_sdram_responder.sv
// Bench for sdram_responder: expected read beats are queued at command time
// and compared as the pins produce them.
module tb_sdram_responder;
    localparam logic [2:0] C_LMR = 3'b000;
    localparam logic [2:0] C_REF = 3'b001;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_BST = 3'b110;
    localparam logic [2:0] C_NOP = 3'b111;

    typedef struct {
        int          due;
        logic [1:0]  oe;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   last_t = 0;
    exp_t sb [$];

    sdram_responder_if bus ();

    sdram_responder #(
        .ROW_BITS(4),
        .COL_BITS(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int due, input logic [1:0] oe, input logic [15:0] data);
        exp_t e;
        e.due  = due;
        e.oe   = oe;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [2:0] c, input logic [1:0] b, input logic [12:0] ad,
                         input logic [15:0] d, input logic [1:0] m);
        @(negedge clk);
        bus.cke   = 1'b1;
        bus.cs_n  = 1'b0;
        {bus.ras_n, bus.cas_n, bus.we_n} = c;
        bus.ba    = b;
        bus.a     = ad;
        bus.dq_in = d;
        bus.dqm   = m;
        last_t    = cyc + 1;
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) drive(C_NOP, 2'd0, 13'd0, 16'd0, 2'b00);
    endtask

    task automatic stall(input int n);
        for (int i = 0; i < n; i++) begin
            drive(C_NOP, 2'd0, 13'd0, 16'd0, 2'b00);
            bus.cke = 1'b0;
        end
    endtask

    // Bank 1 row 3 holds 0x5000+col in columns 0..7 once the BL=8 write is done.
    task automatic rd_expect(input int t, input int cl, input int n, input int start, input int bl);
        int col;
        for (int i = 0; i < n; i++) begin
            col = (start & ~(bl - 1)) | ((start + i) & (bl - 1));
            push(t + cl + i, 2'b11, 16'h5000 + 16'(col));
        end
        push(t + cl + n, 2'b00, 16'h0000);
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [15:0] m;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.due < cyc) begin
                chk("sb_late", 32'(cyc), 32'(e.due));
            end else begin
                chk($sformatf("dq_oe@%0d", e.due), 32'(bus.dq_oe), 32'(e.oe));
                if (e.oe != 2'b00) begin
                    m = {{8{e.oe[1]}}, {8{e.oe[0]}}};
                    chk($sformatf("dq_out@%0d", e.due), 32'(bus.dq_out & m), 32'(e.data & m));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int t;
        rst_n     = 1'b0;
        bus.cke   = 1'b1;
        bus.cs_n  = 1'b1;
        {bus.ras_n, bus.cas_n, bus.we_n} = C_NOP;
        bus.dqm   = 2'b00;
        bus.a     = '0;
        bus.ba    = '0;
        bus.dq_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_dq_oe",  32'(bus.dq_oe), 32'd0);
        chk("rst_dq_out", 32'(bus.dq_out), 32'd0);
        chk("rst_ref",    32'(bus.refresh_cnt), 32'd0);
        chk("rst_err",    32'(bus.cmd_err), 32'd0);
        rst_n = 1'b1;

        // BL=4 CL=2 write then read back
        drive(C_LMR, 2'd0, 13'h022, 16'h0, 2'b00);
        drive(C_ACT, 2'd1, 13'd3, 16'h0, 2'b00);
        drive(C_WR,  2'd1, 13'd0, 16'h1111, 2'b00);
        drive(C_NOP, 2'd0, 13'd0, 16'h2222, 2'b00);
        drive(C_NOP, 2'd0, 13'd0, 16'h3333, 2'b00);
        drive(C_NOP, 2'd0, 13'd0, 16'h4444, 2'b00);
        drive(C_RD,  2'd1, 13'd0, 16'h0, 2'b00);
        t = last_t;
        push(t + 2, 2'b11, 16'h1111);
        push(t + 3, 2'b11, 16'h2222);
        push(t + 4, 2'b11, 16'h3333);
        push(t + 5, 2'b11, 16'h4444);
        push(t + 6, 2'b00, 16'h0000);
        nop(7);

        // byte-masked write, single-beat bursts cut by BURST TERMINATE
        drive(C_WR,  2'd1, 13'd8, 16'h1234, 2'b00);
        drive(C_BST, 2'd0, 13'd0, 16'h0, 2'b00);
        drive(C_WR,  2'd1, 13'd8, 16'hABCD, 2'b10);
        drive(C_BST, 2'd0, 13'd0, 16'h0, 2'b00);
        drive(C_RD,  2'd1, 13'd8, 16'h0, 2'b00);
        t = last_t;
        drive(C_BST, 2'd0, 13'd0, 16'h0, 2'b00);
        push(t + 2, 2'b11, 16'h12CD);
        push(t + 3, 2'b00, 16'h0000);
        nop(4);

        // BL=8 wrap order, then CL=3
        drive(C_PRE, 2'd0, 13'h400, 16'h0, 2'b00);
        drive(C_LMR, 2'd0, 13'h023, 16'h0, 2'b00);
        drive(C_ACT, 2'd1, 13'd3, 16'h0, 2'b00);
        drive(C_WR,  2'd1, 13'd0, 16'h5000, 2'b00);
        for (int k = 1; k < 8; k++) drive(C_NOP, 2'd0, 13'd0, 16'h5000 + 16'(k), 2'b00);
        drive(C_RD,  2'd1, 13'd5, 16'h0, 2'b00);
        rd_expect(last_t, 2, 8, 5, 8);
        nop(11);
        drive(C_PRE, 2'd0, 13'h400, 16'h0, 2'b00);
        drive(C_LMR, 2'd0, 13'h033, 16'h0, 2'b00);
        drive(C_ACT, 2'd1, 13'd3, 16'h0, 2'b00);
        drive(C_RD,  2'd1, 13'd0, 16'h0, 2'b00);
        t = last_t;
        push(t + 2, 2'b00, 16'h0000);
        rd_expect(t, 3, 8, 0, 8);
        nop(12);

        // BURST TERMINATE two cycles after READ
        drive(C_RD,  2'd1, 13'd0, 16'h0, 2'b00);
        rd_expect(last_t, 3, 2, 0, 8);
        drive(C_NOP, 2'd0, 13'd0, 16'h0, 2'b00);
        drive(C_BST, 2'd0, 13'd0, 16'h0, 2'b00);
        nop(6);

        // READ to idle bank, then refresh with all banks idle
        chk("err_clean", 32'(bus.cmd_err), 32'd0);
        drive(C_RD,  2'd2, 13'd0, 16'h0, 2'b00);
        t = last_t;
        push(t + 3, 2'b00, 16'h0000);
        push(t + 4, 2'b00, 16'h0000);
        nop(1);
        chk("err_idle_rd", 32'(bus.cmd_err), 32'd1);
        nop(4);
        drive(C_PRE, 2'd0, 13'h400, 16'h0, 2'b00);
        repeat (3) drive(C_REF, 2'd0, 13'd0, 16'h0, 2'b00);
        nop(1);
        chk("ref_cnt", 32'(bus.refresh_cnt), 32'd3);

        // cke low for three edges while beat 0 is on the pins
        drive(C_ACT, 2'd1, 13'd3, 16'h0, 2'b00);
        drive(C_RD,  2'd1, 13'd0, 16'h0, 2'b00);
        t = last_t;
        for (int i = 3; i <= 6; i++) push(t + i, 2'b11, 16'h5000);
        for (int i = 1; i < 8; i++) push(t + 6 + i, 2'b11, 16'h5000 + 16'(i));
        push(t + 14, 2'b00, 16'h0000);
        nop(3);
        stall(3);
        nop(10);

        // async reset in the middle of a read burst
        drive(C_RD,  2'd1, 13'd0, 16'h0, 2'b00);
        t = last_t;
        push(t + 3, 2'b11, 16'h5000);
        push(t + 4, 2'b11, 16'h5001);
        nop(4);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        chk("rst_mid_oe",  32'(bus.dq_oe), 32'd0);
        chk("rst_mid_err", 32'(bus.cmd_err), 32'd0);
        chk("rst_mid_ref", 32'(bus.refresh_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(C_ACT, 2'd1, 13'd3, 16'h0, 2'b00);
        drive(C_RD,  2'd1, 13'd0, 16'h0, 2'b00);
        t = last_t;
        push(t + 1, 2'b00, 16'h0000);
        push(t + 2, 2'b11, 16'h5000);
        push(t + 3, 2'b00, 16'h0000);
        nop(5);
        chk("post_rst_err", 32'(bus.cmd_err), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
